fsab_rr_arbiter: RTL and testbench

- Parametrised FSAB request arbiter, N-channel successor to the fixed 3-device arbiter.
- Sits between FSAB masters (preload, I-cache, D-cache, future DMA) and FSABMemory.
- Buffers each master's beats in a per-channel credit-managed FIFO, selects among channels round-robin, and holds a grant for a whole write burst.
- Tracks downstream memory credits so it never over-issues.

---
 rtl/fsab_rr_arbiter_pkg.sv | 35 +++
 rtl/fsab_rr_arbiter_chan_fifo.sv | 52 +++++
 rtl/fsab_rr_arbiter.sv | 210 +++++++++++++++++++++
 tb/tb_fsab_rr_arbiter.sv | 335 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fsab_rr_arbiter_pkg.sv
// Shared FSAB definitions for the request arbiter: field widths, mode
// encodings and the beat record that travels through the channel FIFOs.
package fsab_rr_arbiter_pkg;

   localparam int FSAB_REQ_HI  = 0;
   localparam int FSAB_DID_HI  = 3;
   localparam int FSAB_ADDR_HI = 30;
   localparam int FSAB_LEN_HI  = 2;
   localparam int FSAB_DATA_HI = 63;
   localparam int FSAB_MASK_HI = 7;

   localparam logic [FSAB_REQ_HI:0] FSAB_READ  = 1'b0;
   localparam logic [FSAB_REQ_HI:0] FSAB_WRITE = 1'b1;

   // One beat as stored in a channel FIFO and held on the downstream outputs.
   typedef struct packed {
      logic [FSAB_REQ_HI:0]  mode;
      logic [FSAB_DID_HI:0]  did;
      logic [FSAB_DID_HI:0]  subdid;
      logic [FSAB_ADDR_HI:0] addr;
      logic [FSAB_LEN_HI:0]  len;
      logic [FSAB_DATA_HI:0] data;
      logic [FSAB_MASK_HI:0] mask;
   } fsab_beat_t;

   localparam int FSAB_BEAT_W = $bits(fsab_beat_t);

   localparam logic [FSAB_LEN_HI:0] FSAB_LEN_ONE = {{FSAB_LEN_HI{1'b0}}, 1'b1};

   // True when a header beat opens a multi-beat write burst (len 0 counts as 1).
   function automatic logic fsab_is_burst(input fsab_beat_t hdr);
      return (hdr.mode == FSAB_WRITE) && (hdr.len > FSAB_LEN_ONE);
   endfunction

endpackage

// File: rtl/fsab_rr_arbiter_chan_fifo.sv
// Per-channel beat FIFO for the FSAB arbiter. The head entry is read
// combinationally so the arbiter can decide and pop in the same cycle;
// storage is a plain array suited to distributed RAM.
module fsab_rr_arbiter_chan_fifo
   import fsab_rr_arbiter_pkg::*;
#(
   parameter int DEPTH = 8
) (
   input  logic       clk_i,
   input  logic       rst_b_i,
   input  logic       push_i,
   input  fsab_beat_t push_beat_i,
   input  logic       pop_i,
   output fsab_beat_t head_o,
   output logic       full_o,
   output logic       empty_o
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

   fsab_beat_t  mem_q [DEPTH];
   logic [AW:0] wr_ptr_q;
   logic [AW:0] rd_ptr_q;
   logic        do_push;
   logic        do_pop;

   // Pointers carry one wrap bit so full and empty are distinguishable.
   assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                    (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
   assign empty_o = (wr_ptr_q == rd_ptr_q);
   assign do_push = push_i && !full_o;
   assign do_pop  = pop_i && !empty_o;
   assign head_o  = mem_q[rd_ptr_q[AW-1:0]];

   // Advance read/write pointers; a push into a full FIFO is discarded.
   always_ff @(posedge clk_i) begin
      if (!rst_b_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         if (do_push) wr_ptr_q <= wr_ptr_q + PTR_ONE;
         if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
      end
   end

   // Beat storage write port.
   always_ff @(posedge clk_i) begin
      if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= push_beat_i;
   end

endmodule

// File: rtl/fsab_rr_arbiter.sv
// N-channel FSAB request arbiter: buffers each master's beats in a
// credit-managed FIFO, grants round-robin, locks the grant for a whole
// write burst and never issues without a downstream memory credit.
// Build option FSAB_ARB_PRIO_EN: highest-index channel has strict
// priority whenever the arbiter is idle.
module fsab_rr_arbiter
   import fsab_rr_arbiter_pkg::*;
#(
   parameter int FSAB_DEVICES       = 3,
   parameter int FIFO_DEPTH         = 8,
   parameter int DOWNSTREAM_CREDITS = 16
) (
   input  logic                                     clk,
   input  logic                                     rst_b,
   input  logic [FSAB_DEVICES-1:0]                  fsabo_valids,
   input  logic [FSAB_DEVICES*(FSAB_REQ_HI+1)-1:0]  fsabo_modes,
   input  logic [FSAB_DEVICES*(FSAB_DID_HI+1)-1:0]  fsabo_dids,
   input  logic [FSAB_DEVICES*(FSAB_DID_HI+1)-1:0]  fsabo_subdids,
   input  logic [FSAB_DEVICES*(FSAB_ADDR_HI+1)-1:0] fsabo_addrs,
   input  logic [FSAB_DEVICES*(FSAB_LEN_HI+1)-1:0]  fsabo_lens,
   input  logic [FSAB_DEVICES*(FSAB_DATA_HI+1)-1:0] fsabo_datas,
   input  logic [FSAB_DEVICES*(FSAB_MASK_HI+1)-1:0] fsabo_masks,
   output logic [FSAB_DEVICES-1:0]                  fsabo_credits,
   output logic                                     fsabo_valid,
   output logic [FSAB_REQ_HI:0]                     fsabo_mode,
   output logic [FSAB_DID_HI:0]                     fsabo_did,
   output logic [FSAB_DID_HI:0]                     fsabo_subdid,
   output logic [FSAB_ADDR_HI:0]                    fsabo_addr,
   output logic [FSAB_LEN_HI:0]                     fsabo_len,
   output logic [FSAB_DATA_HI:0]                    fsabo_data,
   output logic [FSAB_MASK_HI:0]                    fsabo_mask,
   input  logic                                     fsabo_credit
);

   localparam int N      = FSAB_DEVICES;
   localparam int CH_W   = (N > 1) ? $clog2(N) : 1;
   localparam int CNT_W  = $clog2(DOWNSTREAM_CREDITS + 1);
   localparam int MODE_W = FSAB_REQ_HI + 1;
   localparam int DID_W  = FSAB_DID_HI + 1;
   localparam int ADDR_W = FSAB_ADDR_HI + 1;
   localparam int LEN_W  = FSAB_LEN_HI + 1;
   localparam int DATA_W = FSAB_DATA_HI + 1;
   localparam int MASK_W = FSAB_MASK_HI + 1;

   localparam logic [CH_W-1:0]  CH_ONE  = CH_W'(1);
   localparam logic [CH_W-1:0]  LAST_CH = CH_W'(N - 1);
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DOWNSTREAM_CREDITS);

   typedef enum logic {ST_IDLE, ST_BURST} state_t;

   fsab_beat_t push_beat [N];
   fsab_beat_t head_beat [N];
   logic [N-1:0] fifo_push;
   logic [N-1:0] fifo_full;
   logic [N-1:0] fifo_empty;
   logic [N-1:0] fifo_pop;

   state_t           state_q;
   logic [CH_W-1:0]  ptr_q;
   logic [CH_W-1:0]  grant_q;
   logic [LEN_W-1:0] remaining_q;
   logic             prio_lock_q;
   logic [CNT_W-1:0] credit_cnt_q;
   logic             valid_q;
   logic [N-1:0]     credits_q;
   fsab_beat_t       out_beat_q;

   logic [CH_W-1:0]  scan_idx;
   logic             sel_found;
   logic [CH_W-1:0]  sel_ch;
   logic             sel_prio;
   logic             issue_d;
   logic [CH_W-1:0]  issue_ch_d;
   fsab_beat_t       issue_beat;

   genvar gi;
   generate
      for (gi = 0; gi < N; gi++) begin : g_chan
         assign push_beat[gi] = '{
            mode:   fsabo_modes  [gi*MODE_W +: MODE_W],
            did:    fsabo_dids   [gi*DID_W  +: DID_W],
            subdid: fsabo_subdids[gi*DID_W  +: DID_W],
            addr:   fsabo_addrs  [gi*ADDR_W +: ADDR_W],
            len:    fsabo_lens   [gi*LEN_W  +: LEN_W],
            data:   fsabo_datas  [gi*DATA_W +: DATA_W],
            mask:   fsabo_masks  [gi*MASK_W +: MASK_W]
         };
         // A beat offered to a full FIFO is a master protocol error and is dropped.
         assign fifo_push[gi] = fsabo_valids[gi] && !fifo_full[gi];
         assign fifo_pop[gi]  = issue_d && (issue_ch_d == CH_W'(gi));

         fsab_rr_arbiter_chan_fifo #(
            .DEPTH(FIFO_DEPTH)
         ) u_fifo (
            .clk_i       (clk),
            .rst_b_i     (rst_b),
            .push_i      (fifo_push[gi]),
            .push_beat_i (push_beat[gi]),
            .pop_i       (fifo_pop[gi]),
            .head_o      (head_beat[gi]),
            .full_o      (fifo_full[gi]),
            .empty_o     (fifo_empty[gi])
         );
      end
   endgenerate

   // Round-robin scan from ptr+1; the priority channel, when enabled, overrides it.
   always_comb begin
      sel_found = 1'b0;
      sel_ch    = '0;
      sel_prio  = 1'b0;
      scan_idx  = ptr_q;
      for (int k = 0; k < N; k++) begin
         scan_idx = (scan_idx == LAST_CH) ? '0 : scan_idx + CH_ONE;
         if (!sel_found && !fifo_empty[scan_idx]) begin
            sel_found = 1'b1;
            sel_ch    = scan_idx;
         end
      end
`ifdef FSAB_ARB_PRIO_EN
      if (!fifo_empty[LAST_CH]) begin
         sel_found = 1'b1;
         sel_ch    = LAST_CH;
         sel_prio  = 1'b1;
      end
`endif
   end

   // Decide whether a beat leaves a FIFO this cycle and from which channel.
   always_comb begin
      issue_d    = 1'b0;
      issue_ch_d = grant_q;
      if (state_q == ST_IDLE) begin
         issue_d    = sel_found && (credit_cnt_q != '0);
         issue_ch_d = sel_ch;
      end else begin
         issue_d    = !fifo_empty[grant_q] && (credit_cnt_q != '0);
      end
   end

   assign issue_beat = head_beat[issue_ch_d];

   // Downstream credit counter: spend on issue, refill on return, saturate at the initial value.
   always_ff @(posedge clk) begin
      if (!rst_b) begin
         credit_cnt_q <= CNT_MAX;
      end else if (issue_d && !fsabo_credit) begin
         credit_cnt_q <= credit_cnt_q - CNT_ONE;
      end else if (!issue_d && fsabo_credit && (credit_cnt_q != CNT_MAX)) begin
         credit_cnt_q <= credit_cnt_q + CNT_ONE;
      end
   end

   // Grant FSM with registered downstream beat and per-channel credit pulses.
   always_ff @(posedge clk) begin
      if (!rst_b) begin
         state_q     <= ST_IDLE;
         ptr_q       <= LAST_CH;
         grant_q     <= '0;
         remaining_q <= '0;
         prio_lock_q <= 1'b0;
         valid_q     <= 1'b0;
         credits_q   <= '0;
         out_beat_q  <= '0;
      end else begin
         valid_q   <= issue_d;
         credits_q <= fifo_pop;
         case (state_q)
            ST_IDLE: begin
               if (issue_d) begin
                  out_beat_q <= issue_beat;
                  grant_q    <= sel_ch;
                  if (fsab_is_burst(issue_beat)) begin
                     remaining_q <= issue_beat.len - FSAB_LEN_ONE;
                     prio_lock_q <= sel_prio;
                     state_q     <= ST_BURST;
                  end else if (!sel_prio) begin
                     ptr_q <= sel_ch;
                  end
               end
            end
            ST_BURST: begin
               if (issue_d) begin
                  // Data beats refresh only data/mask; header fields stay on the bus.
                  out_beat_q.data <= issue_beat.data;
                  out_beat_q.mask <= issue_beat.mask;
                  remaining_q     <= remaining_q - FSAB_LEN_ONE;
                  if (remaining_q == FSAB_LEN_ONE) begin
                     state_q <= ST_IDLE;
                     if (!prio_lock_q) ptr_q <= grant_q;
                  end
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign fsabo_valid   = valid_q;
   assign fsabo_credits = credits_q;
   assign fsabo_mode    = out_beat_q.mode;
   assign fsabo_did     = out_beat_q.did;
   assign fsabo_subdid  = out_beat_q.subdid;
   assign fsabo_addr    = out_beat_q.addr;
   assign fsabo_len     = out_beat_q.len;
   assign fsabo_data    = out_beat_q.data;
   assign fsabo_mask    = out_beat_q.mask;

endmodule

// File: tb/tb_fsab_rr_arbiter.sv
// Self-checking bench for fsab_rr_arbiter: randomized masters and memory
// credit returns, checked every cycle against a queue-based reference model,
// plus directed scenarios for latency, ordering, burst lock, credit stall,
// FIFO overflow, reset mid-burst and (with FSAB_ARB_PRIO_EN) priority.
module tb_fsab_rr_arbiter;
   import fsab_rr_arbiter_pkg::*;

   localparam int N     = 3;
   localparam int DEPTH = 8;
   localparam int DC    = 16;
`ifdef FSAB_ARB_PRIO_EN
   localparam bit PRIO_EN = 1'b1;
`else
   localparam bit PRIO_EN = 1'b0;
`endif

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic           rst_b;
   logic [N-1:0]   valids;
   logic [N*1-1:0]  modes;
   logic [N*4-1:0]  dids, subdids;
   logic [N*31-1:0] addrs;
   logic [N*3-1:0]  lens;
   logic [N*64-1:0] datas;
   logic [N*8-1:0]  masks;
   logic [N-1:0]   credits;
   logic           o_valid;
   logic [0:0]     o_mode;
   logic [3:0]     o_did, o_subdid;
   logic [30:0]    o_addr;
   logic [2:0]     o_len;
   logic [63:0]    o_data;
   logic [7:0]     o_mask;
   logic           mem_credit;

   fsab_rr_arbiter #(.FSAB_DEVICES(N), .FIFO_DEPTH(DEPTH), .DOWNSTREAM_CREDITS(DC)) dut (
      .clk(clk), .rst_b(rst_b), .fsabo_valids(valids), .fsabo_modes(modes),
      .fsabo_dids(dids), .fsabo_subdids(subdids), .fsabo_addrs(addrs),
      .fsabo_lens(lens), .fsabo_datas(datas), .fsabo_masks(masks),
      .fsabo_credits(credits), .fsabo_valid(o_valid), .fsabo_mode(o_mode),
      .fsabo_did(o_did), .fsabo_subdid(o_subdid), .fsabo_addr(o_addr),
      .fsabo_len(o_len), .fsabo_data(o_data), .fsabo_mask(o_mask),
      .fsabo_credit(mem_credit));

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   // ---------------- stimulus state ----------------
   fsab_beat_t pend [N][$];
   int  m_credit [N];
   int  gen_pct, push_pct, ret_pct, outstanding, cycle_no;
   bit  force_credit, ignore_credit;
   logic [30:0] seen_addr [$];
   int          seen_ch [$];

   // ---------------- reference model ----------------
   fsab_beat_t mq [N][$];
   int  m_cnt, m_ptr, m_grant, m_rem;
   bit  m_burst, m_plock, m_rst_seen;
   fsab_beat_t exp_beat;
   logic       exp_valid;
   logic [N-1:0] exp_credits;

   function automatic fsab_beat_t in_beat(input int ch);
      fsab_beat_t b;
      b.mode = modes[ch]; b.did = dids[ch*4 +: 4]; b.subdid = subdids[ch*4 +: 4];
      b.addr = addrs[ch*31 +: 31]; b.len = lens[ch*3 +: 3];
      b.data = datas[ch*64 +: 64]; b.mask = masks[ch*8 +: 8];
      return b;
   endfunction

   task automatic model_step();
      int sz [N];
      int g, beats;
      bit found, issued;
      fsab_beat_t b;
      if (!rst_b) begin
         for (int c = 0; c < N; c++) mq[c].delete();
         m_cnt = DC; m_ptr = N - 1; m_burst = 0; m_plock = 0;
         exp_valid = 0; exp_credits = '0; exp_beat = '0; m_rst_seen = 1;
         return;
      end
      m_rst_seen = 0;
      for (int c = 0; c < N; c++) sz[c] = mq[c].size();
      issued = 0; g = 0; found = 0;
      if (m_cnt > 0) begin
         if (!m_burst) begin
            if (PRIO_EN && sz[N-1] > 0) begin found = 1; g = N - 1; end
            for (int k = 1; k <= N && !found; k++)
               if (sz[(m_ptr + k) % N] > 0) begin found = 1; g = (m_ptr + k) % N; end
            if (found) begin
               b = mq[g].pop_front();
               exp_beat = b; issued = 1;
               beats = (b.mode == FSAB_WRITE) ? ((b.len == 0) ? 1 : int'(b.len)) : 1;
               if (beats > 1) begin
                  m_burst = 1; m_grant = g; m_rem = beats - 1;
                  m_plock = PRIO_EN && (g == N - 1);
               end else if (!(PRIO_EN && g == N - 1)) m_ptr = g;
            end
         end else if (sz[m_grant] > 0) begin
            g = m_grant;
            b = mq[g].pop_front();
            exp_beat.data = b.data; exp_beat.mask = b.mask; issued = 1;
            m_rem--;
            if (m_rem == 0) begin m_burst = 0; if (!m_plock) m_ptr = g; end
         end
      end
      exp_valid = issued;
      exp_credits = '0;
      if (issued) exp_credits[g] = 1'b1;
      for (int c = 0; c < N; c++)
         if (valids[c] && sz[c] < DEPTH) mq[c].push_back(in_beat(c));
      m_cnt = m_cnt - int'(issued) + int'(mem_credit);
      if (m_cnt > DC) m_cnt = DC;
   endtask

   // ---------------- masters and memory ----------------
   task automatic make_pkt(input int ch, input bit wr, input logic [30:0] addr, input logic [2:0] len);
      fsab_beat_t b;
      int n;
      b.mode = wr ? FSAB_WRITE : FSAB_READ; b.did = 4'(ch); b.subdid = 4'($urandom);
      b.addr = addr; b.len = len; b.data = {$urandom, $urandom}; b.mask = 8'($urandom);
      pend[ch].push_back(b);
      n = wr ? ((len == 0) ? 1 : int'(len)) : 1;
      for (int j = 1; j < n; j++) begin
         b.mode = 1'($urandom); b.did = 4'($urandom); b.subdid = 4'($urandom);
         b.addr = 31'($urandom); b.len = 3'($urandom);
         b.data = {$urandom, $urandom}; b.mask = 8'($urandom);
         pend[ch].push_back(b);
      end
   endtask

   task automatic drive_inputs();
      fsab_beat_t b;
      for (int c = 0; c < N; c++) begin
         valids[c] = 1'b0;
         modes[c] = 1'($urandom); dids[c*4 +: 4] = 4'($urandom); subdids[c*4 +: 4] = 4'($urandom);
         addrs[c*31 +: 31] = 31'($urandom); lens[c*3 +: 3] = 3'($urandom);
         datas[c*64 +: 64] = {$urandom, $urandom}; masks[c*8 +: 8] = 8'($urandom);
      end
      mem_credit = 1'b0;
      if (!rst_b) return;
      for (int c = 0; c < N; c++) begin
         if (gen_pct > 0 && pend[c].size() == 0 && $urandom_range(99) < gen_pct)
            make_pkt(c, 1'($urandom), 31'($urandom), 3'($urandom));
         if (pend[c].size() > 0 && (m_credit[c] > 0 || (ignore_credit && c == 0))
             && $urandom_range(99) < push_pct) begin
            b = pend[c].pop_front();
            m_credit[c]--;
            valids[c] = 1'b1;
            modes[c] = b.mode; dids[c*4 +: 4] = b.did; subdids[c*4 +: 4] = b.subdid;
            addrs[c*31 +: 31] = b.addr; lens[c*3 +: 3] = b.len;
            datas[c*64 +: 64] = b.data; masks[c*8 +: 8] = b.mask;
         end
      end
      if (force_credit) mem_credit = 1'b1;
      else if (outstanding > 0 && $urandom_range(99) < ret_pct) mem_credit = 1'b1;
      else if (outstanding == 0 && ret_pct > 0 && $urandom_range(99) < 3) mem_credit = 1'b1;
      if (mem_credit && outstanding > 0) outstanding--;
   endtask

   task automatic compare();
      check("valid", o_valid, exp_valid);
      check("credits", credits, exp_credits);
      if (exp_valid || m_rst_seen) begin
         check("mode", o_mode, exp_beat.mode);
         check("did", o_did, exp_beat.did);
         check("subdid", o_subdid, exp_beat.subdid);
         check("addr", o_addr, exp_beat.addr);
         check("len", o_len, exp_beat.len);
         check("data", o_data, exp_beat.data);
         check("mask", o_mask, exp_beat.mask);
      end
   endtask

   task automatic tick();
      drive_inputs();
      @(posedge clk);
      model_step();
      #1;
      compare();
      cycle_no++;
      for (int c = 0; c < N; c++) begin
         if (credits[c]) begin
            m_credit[c]++;
            if (o_valid) seen_ch.push_back(c);
         end
      end
      if (o_valid) begin
         outstanding++;
         seen_addr.push_back(o_addr);
         $display("cycle %0d beat mode=%0d did=%0h addr=%0h len=%0d data=%0h mask=%0h",
                  cycle_no, o_mode, o_did, o_addr, o_len, o_data, o_mask);
      end
   endtask

   task automatic do_reset();
      rst_b = 1'b0;
      for (int c = 0; c < N; c++) begin pend[c].delete(); m_credit[c] = DEPTH; end
      outstanding = 0;
      tick(); tick();
      rst_b = 1'b1;
      seen_addr.delete(); seen_ch.delete();
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      int exp_first, exp_second, nbeats, n0;
      gen_pct = 0; push_pct = 100; ret_pct = 0; force_credit = 0; ignore_credit = 0;
      cycle_no = 0; valids = '0; mem_credit = 1'b0;
      do_reset();

      // Single read on channel 1: visible two cycles after the push.
      make_pkt(1, 1'b0, 31'h100, 3'd0);
      tick();
      check("lat_t1_valid", o_valid, 1'b0);
      tick();
      check("lat_t2_valid", o_valid, 1'b1);
      check("lat_t2_addr", o_addr, 31'h100);
      check("lat_t2_credits", credits, 3'b010);

      // Three simultaneous reads, two rounds: order starts at channel 0.
      ret_pct = 100;
      do_reset();
      for (int r = 0; r < 2; r++) begin
         for (int c = 0; c < N; c++) make_pkt(c, 1'b0, 31'(32'h200 + c), 3'd1);
         for (int i = 0; i < 6; i++) tick();
      end
      check("rr_count", seen_ch.size(), 6);
      for (int i = 0; i < 6 && i < seen_ch.size(); i++)
         check("rr_order", seen_ch[i], PRIO_EN ? ((i % 3 == 0) ? 2 : (i % 3) - 1) : (i % 3));

      // Write burst of 4 on channel 0 with a competing read on channel 1.
      do_reset();
      make_pkt(0, 1'b1, 31'h300, 3'd4);
      make_pkt(1, 1'b0, 31'h310, 3'd0);
      for (int i = 0; i < 10; i++) tick();
      check("burst_count", seen_ch.size(), 5);
      for (int i = 0; i < 5 && i < seen_ch.size(); i++) begin
         check("burst_ch", seen_ch[i], (i < 4) ? 0 : 1);
         check("burst_addr", seen_addr[i], (i < 4) ? 31'h300 : 31'h310);
      end

      // Downstream credit exhaustion mid-burst, single credit, then FIFO overflow.
      ret_pct = 0;
      do_reset();
      for (int i = 0; i < 7; i++) begin make_pkt(0, 1'b0, 31'(i), 3'd0); make_pkt(1, 1'b0, 31'(i), 3'd0); end
      for (int i = 0; i < 25; i++) tick();
      check("drain14", seen_ch.size(), 14);
      make_pkt(2, 1'b1, 31'h2A0, 3'd4);
      nbeats = seen_ch.size();
      for (int i = 0; i < 12; i++) tick();
      check("stall_two_beats", seen_ch.size() - nbeats, 2);
      check("stall_valid_low", o_valid, 1'b0);
      force_credit = 1; tick(); force_credit = 0;
      nbeats = seen_ch.size();
      for (int i = 0; i < 6; i++) tick();
      check("one_credit_one_beat", seen_ch.size() - nbeats, 1);
      ignore_credit = 1;
      for (int i = 0; i < 10; i++) make_pkt(0, 1'b0, 31'(32'h600 + i), 3'd0);
      for (int i = 0; i < 12; i++) tick();
      ignore_credit = 0;
      seen_ch.delete(); seen_addr.delete();
      ret_pct = 100;
      for (int i = 0; i < 40; i++) tick();
      n0 = 0;
      foreach (seen_ch[i]) if (seen_ch[i] == 0) n0++;
      check("overflow_drop", n0, DEPTH);

      // Reset in the middle of a burst.
      do_reset();
      make_pkt(0, 1'b1, 31'h400, 3'd4);
      for (int i = 0; i < 20 && seen_addr.size() < 2; i++) tick();
      check("rst_two_beats", seen_addr.size() >= 2, 1'b1);
      rst_b = 1'b0;
      for (int c = 0; c < N; c++) begin pend[c].delete(); m_credit[c] = DEPTH; end
      outstanding = 0;
      tick();
      check("rst_valid_low", o_valid, 1'b0);
      rst_b = 1'b1;
      seen_addr.delete(); seen_ch.delete();
      make_pkt(1, 1'b0, 31'h500, 3'd0);
      for (int i = 0; i < 6; i++) tick();
      check("post_rst_count", seen_addr.size(), 1);
      if (seen_addr.size() > 0) begin
         check("post_rst_addr", seen_addr[0], 31'h500);
         check("post_rst_ch", seen_ch[0], 1);
      end

      // Channels 0 and 2 contend every round.
      do_reset();
      exp_first  = PRIO_EN ? 2 : 0;
      exp_second = PRIO_EN ? 0 : 2;
      for (int r = 0; r < 4; r++) begin
         make_pkt(0, 1'b0, 31'h700, 3'd0);
         make_pkt(2, 1'b0, 31'h720, 3'd0);
         for (int i = 0; i < 4; i++) tick();
      end
      check("pair_count", seen_ch.size(), 8);
      for (int r = 0; r < 4 && 2*r+1 < seen_ch.size(); r++) begin
         check("pair_first", seen_ch[2*r], exp_first);
         check("pair_second", seen_ch[2*r+1], exp_second);
      end

      // Randomized traffic with varying memory credit return behaviour.
      do_reset();
      gen_pct = 25; push_pct = 70; ret_pct = 70;
      for (int i = 0; i < 400; i++) tick();
      ret_pct = 0;
      for (int i = 0; i < 60; i++) tick();
      ret_pct = 90;
      for (int i = 0; i < 300; i++) tick();
      gen_pct = 0; push_pct = 100; ret_pct = 100;
      for (int i = 0; i < 120; i++) tick();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
